// File: rtl/tx_axis_frame_fifo.sv
// tx_axis_frame_fifo: store-and-forward AXIS frame FIFO feeding the tx encoder; drops errored/overflowing frames
module tx_axis_frame_fifo #(
   parameter int ADDR_W = 9,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic [31:0]       s_tdata_i,
   input  logic [1:0]        s_tvldb_i,
   input  logic              s_tvalid_i,
   output logic              s_tready_o,
   input  logic              s_tlast_i,
   input  logic              s_tuser_i,
   output logic [31:0]       m_tdata_o,
   output logic [1:0]        m_tvldb_o,
   output logic              m_tvalid_o,
   input  logic              m_tready_i,
   output logic              m_tlast_o,
   output logic              m_tuser_o,
   output logic [ADDR_W:0]   frame_cnt_o,
   output logic [CNT_W-1:0]  drop_cnt_o
);
   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [1:0] {IDLE, STORE, DROP} wr_state_e;

   wr_state_e         state_q, state_d;
   logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q;
   logic [ADDR_W:0]   frame_cnt_q, frame_cnt_d;
   logic [CNT_W-1:0]  drop_cnt_q;
   logic [34:0]       mem [0:(1<<ADDR_W)-1];
   logic [34:0]       ram_q, e0_q, e0_d, e1_q, e1_d;
   logic [1:0]        cnt_q, cnt_d, occ, after_pop;
   logic              rdy_q, rd_vld_q, acc, full, wr_en, commit, drop, pop, last_pop, issue;

   assign acc       = s_tvalid_i & rdy_q;
   assign full      = (wr_ptr_q - rd_ptr_q) == DEPTH;
   assign pop       = (cnt_q != 2'd0) & m_tready_i;
   assign last_pop  = pop & e0_q[34];
   assign after_pop = cnt_q - {1'b0, pop};
   assign occ       = cnt_q + {1'b0, rd_vld_q};
   // a read may only be issued if its data is guaranteed a skid slot one cycle later
   assign issue     = (rd_ptr_q != commit_ptr_q) & ((occ < 2'd2) | ((occ == 2'd2) & pop));
   assign frame_cnt_d = (commit & ~last_pop) ? frame_cnt_q + 1'b1 :
                        (~commit & last_pop) ? frame_cnt_q - 1'b1 : frame_cnt_q;

   assign s_tready_o  = rdy_q;
   assign m_tvalid_o  = cnt_q != 2'd0;
   assign {m_tlast_o, m_tvldb_o, m_tdata_o} = e0_q;
   assign m_tuser_o   = 1'b0;
   assign frame_cnt_o = frame_cnt_q;
   assign drop_cnt_o  = drop_cnt_q;

   // write-side state machine: store, commit on good tlast, roll back on error or overflow
   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      commit_ptr_d = commit_ptr_q;
      wr_en        = 1'b0;
      commit       = 1'b0;
      drop         = 1'b0;
      if (acc) begin
         if (state_q == DROP || full) begin
            state_d = s_tlast_i ? IDLE : DROP;
            drop    = s_tlast_i;
         end else begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            state_d  = s_tlast_i ? IDLE : STORE;
            commit   = s_tlast_i & ~s_tuser_i;
            drop     = s_tlast_i & s_tuser_i;
         end
         if (commit) commit_ptr_d = wr_ptr_q + 1'b1;
         if (drop) wr_ptr_d = commit_ptr_q;
      end
   end

   // two-entry output skid: entry 0 drives the m_* outputs, new data lands in the first free slot
   always_comb begin
      e0_d  = pop ? e1_q : e0_q;
      e1_d  = e1_q;
      cnt_d = after_pop + {1'b0, rd_vld_q};
      if (rd_vld_q && after_pop == 2'd0) e0_d = ram_q;
      if (rd_vld_q && after_pop != 2'd0) e1_d = ram_q;
   end

   // beat storage with synchronous write and one-cycle registered read
   always_ff @(posedge clk_i) begin
      if (wr_en) mem[wr_ptr_q[ADDR_W-1:0]] <= {s_tlast_i, s_tvldb_i, s_tdata_i};
      if (issue) ram_q <= mem[rd_ptr_q[ADDR_W-1:0]];
   end

   // pointers, counters and output registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= IDLE;
         wr_ptr_q     <= '0;
         commit_ptr_q <= '0;
         rd_ptr_q     <= '0;
         rd_vld_q     <= 1'b0;
         rdy_q        <= 1'b0;
         frame_cnt_q  <= '0;
         drop_cnt_q   <= '0;
         cnt_q        <= 2'd0;
         e0_q         <= '0;
         e1_q         <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         commit_ptr_q <= commit_ptr_d;
         rd_ptr_q     <= rd_ptr_q + {{ADDR_W{1'b0}}, issue};
         rd_vld_q     <= issue;
         rdy_q        <= 1'b1;
         frame_cnt_q  <= frame_cnt_d;
         drop_cnt_q   <= (drop && drop_cnt_q != '1) ? drop_cnt_q + 1'b1 : drop_cnt_q;
         cnt_q        <= cnt_d;
         e0_q         <= e0_d;
         e1_q         <= e1_d;
      end
   end
endmodule

// File: tb/tb_tx_axis_frame_fifo.sv
// tb_tx_axis_frame_fifo: randomized and directed checks of the frame FIFO against a frame-queue model
module tb_tx_axis_frame_fifo;
   localparam int AW    = 4;
   localparam int DEPTH = 1 << AW;
   localparam int CW    = 16;

   logic           clk_i = 1'b0, rst_n_i = 1'b0;
   logic [31:0]    s_tdata_i = '0, m_tdata_o;
   logic [1:0]     s_tvldb_i = '0, m_tvldb_o;
   logic           s_tvalid_i = 1'b0, s_tready_o, s_tlast_i = 1'b0, s_tuser_i = 1'b0;
   logic           m_tvalid_o, m_tready_i = 1'b0, m_tlast_o, m_tuser_o;
   logic [AW:0]    frame_cnt_o;
   logic [CW-1:0]  drop_cnt_o;

   always #5 clk_i = ~clk_i;

   tx_axis_frame_fifo #(.ADDR_W(AW), .CNT_W(CW)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .s_tdata_i(s_tdata_i), .s_tvldb_i(s_tvldb_i), .s_tvalid_i(s_tvalid_i), .s_tready_o(s_tready_o),
      .s_tlast_i(s_tlast_i), .s_tuser_i(s_tuser_i),
      .m_tdata_o(m_tdata_o), .m_tvldb_o(m_tvldb_o), .m_tvalid_o(m_tvalid_o), .m_tready_i(m_tready_i),
      .m_tlast_o(m_tlast_o), .m_tuser_o(m_tuser_o),
      .frame_cnt_o(frame_cnt_o), .drop_cnt_o(drop_cnt_o)
   );

   int          vec = 0, miss = 0, cyc = 0, up_edges = 0;
   int          dlv_beats = 0, mdl_frames = 0, mdl_drops = 0, rdy_mode = 0, pi = 0;
   int          dlv_cyc[$], last_pos[$];
   logic [34:0] exp_q[$], cur_q[$];
   logic        in_frame = 1'b0, prev_stall = 1'b0, gaps = 1'b0;
   logic [35:0] prev_out = '0;

   task automatic chk(input string name, input longint act, input longint exp);
      vec++;
      if (act != exp) begin
         miss++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk_i) cyc <= cyc + 1;

   always @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) up_edges <= 0;
      else up_edges <= up_edges + 1;

   initial forever begin
      @(posedge clk_i); #1;
      if (rdy_mode == 1) m_tready_i = ($urandom_range(9) < 7);
      else if (rdy_mode == 2) begin
         m_tready_i = (pi % 4 == 0) || (pi % 4 == 3);
         pi++;
      end
   end

   // model: accepted frames are queued as beats; good frames of at most DEPTH beats are forwarded in order
   always @(negedge clk_i) begin
      if (!rst_n_i) begin
         chk("rst s_tready", s_tready_o, 0);
         chk("rst m_tvalid", m_tvalid_o, 0);
         chk("rst m_tdata", m_tdata_o, 0);
         chk("rst m_tvldb", m_tvldb_o, 0);
         chk("rst m_tlast", m_tlast_o, 0);
         chk("rst m_tuser", m_tuser_o, 0);
         chk("rst frame_cnt", frame_cnt_o, 0);
         chk("rst drop_cnt", drop_cnt_o, 0);
         exp_q.delete(); cur_q.delete();
         mdl_frames = 0; mdl_drops = 0; in_frame = 1'b0; prev_stall = 1'b0;
      end else begin
         chk("s_tready", s_tready_o, up_edges > 0);
         chk("frame_cnt", frame_cnt_o, mdl_frames);
         chk("drop_cnt", drop_cnt_o, mdl_drops);
         chk("m_tuser", m_tuser_o, 0);
         if (prev_stall) chk("stall hold", {m_tvalid_o, m_tlast_o, m_tvldb_o, m_tdata_o}, prev_out);
         if (in_frame) chk("bubble in frame", m_tvalid_o, 1);
         if (exp_q.size() == 0) chk("valid without stored frame", m_tvalid_o, 0);
         if (m_tvalid_o && m_tready_i && exp_q.size() != 0) begin
            logic [34:0] e;
            e = exp_q.pop_front();
            chk("m_tdata", m_tdata_o, e[31:0]);
            chk("m_tlast", m_tlast_o, e[34]);
            if (e[34]) chk("m_tvldb", m_tvldb_o, e[33:32]);
            dlv_beats++;
            dlv_cyc.push_back(cyc);
            if (e[34]) begin
               last_pos.push_back(dlv_beats);
               mdl_frames--;
            end
            in_frame = !e[34];
         end
         if (s_tvalid_i && s_tready_o) begin
            cur_q.push_back({s_tlast_i, s_tvldb_i, s_tdata_i});
            if (s_tlast_i) begin
               if (s_tuser_i || cur_q.size() > DEPTH) begin
                  if (mdl_drops < (1 << CW) - 1) mdl_drops++;
               end else begin
                  foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
                  mdl_frames++;
               end
               cur_q.delete();
            end
         end
         prev_stall = m_tvalid_o && !m_tready_i;
         prev_out   = {m_tvalid_o, m_tlast_o, m_tvldb_o, m_tdata_o};
      end
   end

   task automatic send_frame(input int len, input logic [1:0] vldb, input logic user);
      for (int i = 0; i < len; i++) begin
         while (gaps && $urandom_range(3) == 0) begin
            s_tvalid_i = 1'b0;
            @(posedge clk_i); #1;
         end
         s_tvalid_i = 1'b1;
         s_tdata_i  = $urandom;
         s_tlast_i  = (i == len - 1);
         s_tvldb_i  = s_tlast_i ? vldb : 2'($urandom_range(3));
         s_tuser_i  = s_tlast_i ? user : 1'($urandom_range(1));
         @(posedge clk_i); #1;
      end
      s_tvalid_i = 1'b0; s_tlast_i = 1'b0; s_tuser_i = 1'b0;
   endtask

   task automatic measure_lat(output int n, output int fc);
      n = 0; fc = -1;
      do begin
         @(negedge clk_i);
         n++;
         if (n == 1) fc = int'(frame_cnt_o);
      end while (!m_tvalid_o && n < 20);
      @(posedge clk_i); #1;
   endtask

   task automatic drain(input string name);
      int t = 0;
      while ((exp_q.size() != 0 || m_tvalid_o) && t < 3000) begin
         @(posedge clk_i); #1;
         t++;
      end
      chk(name, exp_q.size(), 0);
   endtask

   task automatic wait_room(input int len);
      int t = 0;
      while (exp_q.size() + len > DEPTH && t < 3000) begin
         @(posedge clk_i); #1;
         t++;
      end
      chk("room for frame", exp_q.size() + len <= DEPTH, 1);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1);
   end

   initial begin
      int n, fc, b0, d0, sz;
      repeat (3) @(posedge clk_i);
      #1 rst_n_i = 1'b1;
      @(posedge clk_i); #1;

      // 16-beat frame, latency 3, frame count 1 then 0
      m_tready_i = 1'b1;
      b0 = dlv_beats;
      send_frame(16, 2'd3, 1'b0);
      measure_lat(n, fc);
      chk("t1 latency", n, 3);
      chk("t1 frame_cnt stored", fc, 1);
      drain("t1 drain");
      chk("t1 beats", dlv_beats - b0, 16);
      chk("t1 frame_cnt end", frame_cnt_o, 0);

      // three frames stored, then released back-to-back
      m_tready_i = 1'b0;
      send_frame(5, 2'd0, 1'b0);
      send_frame(1, 2'd2, 1'b0);
      send_frame(9, 2'd1, 1'b0);
      repeat (4) @(posedge clk_i);
      #1 chk("t2 frame_cnt", frame_cnt_o, 3);
      b0 = dlv_beats;
      m_tready_i = 1'b1;
      drain("t2 drain");
      sz = last_pos.size();
      chk("t2 tlast pos 1", last_pos[sz-3] - b0, 5);
      chk("t2 tlast pos 2", last_pos[sz-2] - b0, 6);
      chk("t2 tlast pos 3", last_pos[sz-1] - b0, 15);
      sz = dlv_cyc.size();
      chk("t2 contiguous", dlv_cyc[sz-1] - dlv_cyc[sz-15], 14);

      // errored frame is discarded
      d0 = int'(drop_cnt_o); b0 = dlv_beats;
      send_frame(8, 2'd3, 1'b1);
      send_frame(4, 2'd2, 1'b0);
      drain("t3 drain");
      chk("t3 drops", int'(drop_cnt_o) - d0, 1);
      chk("t3 beats", dlv_beats - b0, 4);

      // oversize frame into empty FIFO is dropped
      d0 = int'(drop_cnt_o); b0 = dlv_beats;
      send_frame(20, 2'd3, 1'b0);
      send_frame(3, 2'd1, 1'b0);
      drain("t4 drain");
      chk("t4 drops", int'(drop_cnt_o) - d0, 1);
      chk("t4 beats", dlv_beats - b0, 3);

      // stalls with ready pattern 1,0,0,1
      b0 = dlv_beats;
      rdy_mode = 2;
      send_frame(6, 2'd1, 1'b0);
      drain("t5 drain");
      chk("t5 beats", dlv_beats - b0, 6);
      rdy_mode = 1;

      // randomized frames, gaps and backpressure
      gaps = 1'b1;
      for (int f = 0; f < 250; f++) begin
         int len;
         len = ($urandom_range(9) == 0) ? $urandom_range(17, 24) : $urandom_range(1, 16);
         if (len <= DEPTH) wait_room(len);
         send_frame(len, 2'($urandom_range(3)), $urandom_range(9) == 0);
      end
      drain("random drain");
      gaps = 1'b0;
      rdy_mode = 0;

      // reset mid-output and mid-input
      m_tready_i = 1'b1;
      send_frame(6, 2'd2, 1'b0);
      for (int i = 0; i < 5; i++) begin
         s_tvalid_i = 1'b1; s_tdata_i = $urandom; s_tlast_i = 1'b0; s_tvldb_i = 2'd0;
         @(posedge clk_i); #1;
      end
      chk("t6 mid-output", m_tvalid_o, 1);
      s_tvalid_i = 1'b0;
      rst_n_i = 1'b0;
      #1 chk("t6 valid in reset", m_tvalid_o, 0);
      repeat (3) @(posedge clk_i);
      #1 rst_n_i = 1'b1;
      @(posedge clk_i); #1;
      b0 = dlv_beats;
      send_frame(2, 2'd1, 1'b0);
      measure_lat(n, fc);
      chk("t6 latency", n, 3);
      drain("t6 drain");
      chk("t6 beats", dlv_beats - b0, 2);
      chk("t6 drop_cnt", drop_cnt_o, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end
endmodule
